count_monitor: RTL and testbench

- Downstream observer of the 4-bit loadable up/down counter. Samples the counter's `count` output together with copies of the counter's `load`/`reset` controls.
- Produces registered event pulses: wrap-up, wrap-down, compare match. Also keeps a saturating wrap tally, a sticky match flag and a stall (count frozen) indication.
- Feeds status/interrupt logic; has no effect on the counter itself.

---
 rtl/count_monitor_pkg.sv | 19 +
 rtl/mon_sat_counter.sv | 23 ++
 rtl/count_monitor.sv | 154 +++++++++++++++
 tb/tb_count_monitor.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_monitor_pkg.sv
// Shared state type, default sizes and helpers for the count_monitor slice.
package count_monitor_pkg;

    localparam int DEF_CNT_W     = 4;
    localparam int DEF_WRAP_W    = 8;
    localparam int DEF_STALL_CYC = 16;

    typedef enum logic [1:0] {
        MON_INIT    = 2'd0,
        MON_TRACK   = 2'd1,
        MON_STALLED = 2'd2
    } mon_state_e;

    // Width of a down-the-line cycle counter that must reach cyc-1.
    function automatic int ctr_width(input int cyc);
        return (cyc > 2) ? $clog2(cyc) : 1;
    endfunction

endpackage

// File: rtl/mon_sat_counter.sv
// Saturating incrementer; a clear wins over the held value but still counts
// an increment arriving in the same cycle.
module mon_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= inc ? W'(1) : '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/count_monitor.sv
// Observer of a loadable up/down counter: wrap/match pulses, wrap tally, stall.
// Build option: define COUNT_MONITOR_STALL_EN to include the stall detector.
//
//   state       | meaning
//   MON_INIT    | first cycle after reset, prev_q not valid, wraps ignored
//   MON_TRACK   | normal tracking, stall_ctr counts quiet cycles
//   MON_STALLED | count frozen for STALL_CYC cycles, stall asserted
module count_monitor
    import count_monitor_pkg::*;
#(
    parameter int CNT_W     = DEF_CNT_W,
    parameter int WRAP_W    = DEF_WRAP_W,
    parameter int STALL_CYC = DEF_STALL_CYC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CNT_W-1:0]  count,
    input  logic              cnt_load,
    input  logic              cnt_clr,
    input  logic [CNT_W-1:0]  cmp_val,
    input  logic              clr_stat,
    output logic              wrap_up,
    output logic              wrap_dn,
    output logic              match,
    output logic              match_seen,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              stall
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] prev_q;
    logic             ld_q;
    logic             clr_q;
    mon_state_e       state;
    mon_state_e       state_nxt;

    logic             activity;
    logic             eval_wrap;
    logic             force_match;
    logic             wrap_up_ev;
    logic             wrap_dn_ev;
    logic             match_ev;

    // A load or clear explains whatever change is visible this cycle.
    assign activity   = (count != prev_q) || ld_q || clr_q;

    assign wrap_up_ev = eval_wrap && (prev_q == CNT_MAX) && (count == '0)
                        && !ld_q && !clr_q;
    assign wrap_dn_ev = eval_wrap && (prev_q == '0) && (count == CNT_MAX)
                        && !ld_q && !clr_q;
    assign match_ev   = (count == cmp_val) && (activity || force_match);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q     <= '0;
            ld_q       <= 1'b0;
            clr_q      <= 1'b0;
            wrap_up    <= 1'b0;
            wrap_dn    <= 1'b0;
            match      <= 1'b0;
            match_seen <= 1'b0;
        end else begin
            prev_q     <= count;
            ld_q       <= cnt_load;
            clr_q      <= cnt_clr;
            wrap_up    <= wrap_up_ev;
            wrap_dn    <= wrap_dn_ev;
            match      <= match_ev;
            match_seen <= clr_stat ? match_ev : (match_seen || match_ev);
        end
    end

    mon_sat_counter #(
        .W (WRAP_W)
    ) u_wrap_tally (
        .clk   (clk),
        .reset (reset),
        .clr   (clr_stat),
        .inc   (wrap_up_ev || wrap_dn_ev),
        .cnt   (wrap_cnt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= MON_INIT;
        end else begin
            state <= state_nxt;
        end
    end

`ifdef COUNT_MONITOR_STALL_EN

    localparam int               CTR_W    = ctr_width(STALL_CYC);
    localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(STALL_CYC - 1);

    logic [CTR_W-1:0] stall_ctr;
    logic [CTR_W-1:0] stall_ctr_nxt;
    logic             stall_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            MON_INIT:    state_nxt = MON_TRACK;
            MON_TRACK:   if (!activity && (stall_ctr == CTR_LAST)) state_nxt = MON_STALLED;
            MON_STALLED: if (activity) state_nxt = MON_TRACK;
            default:     state_nxt = MON_INIT;
        endcase
    end

    always_comb begin
        eval_wrap     = (state != MON_INIT);
        force_match   = (state == MON_INIT);
        stall_nxt     = (state_nxt == MON_STALLED);
        stall_ctr_nxt = '0;
        if ((state == MON_TRACK) && (state_nxt == MON_TRACK) && !activity) begin
            stall_ctr_nxt = stall_ctr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_ctr <= '0;
            stall     <= 1'b0;
        end else begin
            stall_ctr <= stall_ctr_nxt;
            stall     <= stall_nxt;
        end
    end

`else

    logic unused_stall_cfg;
    assign unused_stall_cfg = (STALL_CYC != 0);

    always_comb begin
        state_nxt = state;
        case (state)
            MON_INIT:  state_nxt = MON_TRACK;
            MON_TRACK: state_nxt = MON_TRACK;
            default:   state_nxt = MON_INIT;
        endcase
    end

    always_comb begin
        eval_wrap   = (state != MON_INIT);
        force_match = (state == MON_INIT);
    end

    assign stall = 1'b0;

`endif

endmodule

// File: tb/tb_count_monitor.sv
// Directed self-checking bench for count_monitor (default parameters).
module tb_count_monitor;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] count;
    logic       cnt_load;
    logic       cnt_clr;
    logic [3:0] cmp_val;
    logic       clr_stat;
    logic       wrap_up;
    logic       wrap_dn;
    logic       match;
    logic       match_seen;
    logic [7:0] wrap_cnt;
    logic       stall;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    count_monitor dut (
        .clk        (clk),
        .reset      (reset),
        .count      (count),
        .cnt_load   (cnt_load),
        .cnt_clr    (cnt_clr),
        .cmp_val    (cmp_val),
        .clr_stat   (clr_stat),
        .wrap_up    (wrap_up),
        .wrap_dn    (wrap_dn),
        .match      (match),
        .match_seen (match_seen),
        .wrap_cnt   (wrap_cnt),
        .stall      (stall)
    );

    // Inputs set before step() apply to the cycle that ends at that edge;
    // outputs read after step() are the registered response to them.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; count = 4'd0; cnt_load = 1'b0; cnt_clr = 1'b0;
        cmp_val = 4'd0; clr_stat = 1'b0;
        step(); step();
        tests++;
        if ({wrap_up, wrap_dn, match, match_seen, wrap_cnt, stall} !== 13'd0) begin
            fails++;
            $display("FAIL reset_outputs: got %b required all zero",
                     {wrap_up, wrap_dn, match, match_seen, wrap_cnt, stall});
        end
        reset = 1'b1;
        step();
        tests++;
        if (match !== 1'b1) begin
            fails++; $display("FAIL init_match: got %b required 1", match);
        end
        tests++;
        if (match_seen !== 1'b1) begin
            fails++; $display("FAIL init_match_seen: got %b required 1", match_seen);
        end
        tests++;
        if ({wrap_up, wrap_dn} !== 2'b00) begin
            fails++; $display("FAIL init_no_wrap: got %b required 00", {wrap_up, wrap_dn});
        end
        step();
        tests++;
        if (match !== 1'b0) begin
            fails++; $display("FAIL init_hold_no_rematch: got %b required 0", match);
        end
    endtask

    task automatic test_wrap_up();
        logic [3:0] seq [4]    = '{4'd14, 4'd15, 4'd0, 4'd1};
        logic       exp_wu [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [7:0] exp_wc [4] = '{8'd0, 8'd0, 8'd1, 8'd1};
        cmp_val = 4'd5; count = 4'd13; clr_stat = 1'b1;
        step();
        clr_stat = 1'b0;
        tests++;
        if (match_seen !== 1'b0) begin
            fails++; $display("FAIL clr_stat_match_seen: got %b required 0", match_seen);
        end
        for (int i = 0; i < 4; i++) begin
            count = seq[i];
            step();
            tests++;
            if (wrap_up !== exp_wu[i] || wrap_dn !== 1'b0 || wrap_cnt !== exp_wc[i]) begin
                fails++;
                $display("FAIL wrap_up_seq[%0d]: got wu=%b wd=%b wc=%0d required wu=%b wd=0 wc=%0d",
                         i, wrap_up, wrap_dn, wrap_cnt, exp_wu[i], exp_wc[i]);
            end
        end
    endtask

    task automatic test_load_clr();
        count = 4'd15; step();
        cnt_load = 1'b1; step();
        count = 4'd0; cmp_val = 4'd0; step();
        tests++;
        if (wrap_up !== 1'b0 || match !== 1'b1 || wrap_cnt !== 8'd1) begin
            fails++;
            $display("FAIL load_no_wrap_up: got wu=%b m=%b wc=%0d required wu=0 m=1 wc=1",
                     wrap_up, match, wrap_cnt);
        end
        count = 4'd15; cnt_load = 1'b0; cnt_clr = 1'b1; step();
        tests++;
        if (wrap_dn !== 1'b0 || wrap_cnt !== 8'd1) begin
            fails++;
            $display("FAIL load_no_wrap_dn: got wd=%b wc=%0d required wd=0 wc=1", wrap_dn, wrap_cnt);
        end
        count = 4'd0; cnt_clr = 1'b0; step();
        tests++;
        if (wrap_up !== 1'b0 || match !== 1'b1) begin
            fails++;
            $display("FAIL clr_no_wrap_up: got wu=%b m=%b required wu=0 m=1", wrap_up, match);
        end
        step();
        tests++;
        if (match !== 1'b0) begin
            fails++; $display("FAIL hold_no_rematch: got %b required 0", match);
        end
        cmp_val = 4'd9; count = 4'd3; step(); step();
        cmp_val = 4'd3; step();
        tests++;
        if (match !== 1'b0) begin
            fails++; $display("FAIL cmp_change_no_match: got %b required 0", match);
        end
    endtask

    task automatic test_wrap_dn_clr();
        cmp_val = 4'd7;
        count = 4'd1; step();
        count = 4'd0; step();
        count = 4'd15; step();
        tests++;
        if (wrap_dn !== 1'b1 || wrap_up !== 1'b0 || wrap_cnt !== 8'd2) begin
            fails++;
            $display("FAIL wrap_dn: got wd=%b wu=%b wc=%0d required wd=1 wu=0 wc=2",
                     wrap_dn, wrap_up, wrap_cnt);
        end
        count = 4'd0; step();
        tests++;
        if (wrap_up !== 1'b1 || wrap_dn !== 1'b0 || wrap_cnt !== 8'd3) begin
            fails++;
            $display("FAIL wrap_up_after_dn: got wu=%b wd=%b wc=%0d required wu=1 wd=0 wc=3",
                     wrap_up, wrap_dn, wrap_cnt);
        end
        count = 4'd15; clr_stat = 1'b1; step();
        tests++;
        if (wrap_dn !== 1'b1 || wrap_cnt !== 8'd1 || match_seen !== 1'b0) begin
            fails++;
            $display("FAIL clr_with_wrap: got wd=%b wc=%0d ms=%b required wd=1 wc=1 ms=0",
                     wrap_dn, wrap_cnt, match_seen);
        end
        cmp_val = 4'd4; count = 4'd4; step();
        clr_stat = 1'b0;
        tests++;
        if (match !== 1'b1 || match_seen !== 1'b1 || wrap_cnt !== 8'd0) begin
            fails++;
            $display("FAIL clr_with_match: got m=%b ms=%b wc=%0d required m=1 ms=1 wc=0",
                     match, match_seen, wrap_cnt);
        end
    endtask

    task automatic test_saturation();
        count = 4'd15; step();
        for (int i = 1; i <= 300; i++) begin
            count = (i % 2 == 1) ? 4'd0 : 4'd15;
            step();
            if (i == 254) begin
                tests++;
                if (wrap_cnt !== 8'd254) begin
                    fails++; $display("FAIL wrap_cnt_254: got %0d required 254", wrap_cnt);
                end
            end
        end
        tests++;
        if (wrap_cnt !== 8'd255) begin
            fails++; $display("FAIL wrap_cnt_sat: got %0d required 255", wrap_cnt);
        end
    endtask

    task automatic test_stall();
        count = 4'd7; step();
`ifdef COUNT_MONITOR_STALL_EN
        for (int j = 1; j <= 16; j++) begin
            step();
            if (j == 15) begin
                tests++;
                if (stall !== 1'b0) begin
                    fails++; $display("FAIL stall_early: got %b required 0", stall);
                end
            end
        end
        tests++;
        if (stall !== 1'b1) begin
            fails++; $display("FAIL stall_set: got %b required 1", stall);
        end
        step(); step(); step();
        tests++;
        if (stall !== 1'b1) begin
            fails++; $display("FAIL stall_held: got %b required 1", stall);
        end
        count = 4'd8; step();
        tests++;
        if (stall !== 1'b0) begin
            fails++; $display("FAIL stall_release: got %b required 0", stall);
        end
`else
        repeat (20) step();
        tests++;
        if (stall !== 1'b0) begin
            fails++; $display("FAIL stall_disabled: got %b required 0", stall);
        end
`endif
        count = 4'd7; cnt_load = 1'b1;
        repeat (24) step();
        cnt_load = 1'b0;
        tests++;
        if (stall !== 1'b0) begin
            fails++; $display("FAIL stall_load_hold: got %b required 0", stall);
        end
    endtask

    task automatic test_reset_mid();
        count = 4'd8; clr_stat = 1'b1; step();
        clr_stat = 1'b0;
        count = 4'd15; step();
        for (int i = 0; i < 5; i++) begin
            count = (i % 2 == 0) ? 4'd0 : 4'd15;
            step();
        end
        tests++;
        if (wrap_cnt !== 8'd5 || wrap_up !== 1'b1) begin
            fails++;
            $display("FAIL pre_reset_state: got wc=%0d wu=%b required wc=5 wu=1", wrap_cnt, wrap_up);
        end
`ifdef COUNT_MONITOR_STALL_EN
        repeat (17) step();
        tests++;
        if (stall !== 1'b1) begin
            fails++; $display("FAIL pre_reset_stall: got %b required 1", stall);
        end
`endif
        reset = 1'b0;
        #1;
        tests++;
        if ({wrap_up, wrap_dn, match, match_seen, wrap_cnt, stall} !== 13'd0) begin
            fails++;
            $display("FAIL async_reset: got %b required all zero",
                     {wrap_up, wrap_dn, match, match_seen, wrap_cnt, stall});
        end
        step();
        reset = 1'b1; count = 4'd15; cmp_val = 4'd15;
        step();
        tests++;
        if (match !== 1'b1 || wrap_dn !== 1'b0) begin
            fails++;
            $display("FAIL post_reset_init: got m=%b wd=%b required m=1 wd=0", match, wrap_dn);
        end
        count = 4'd0; step();
        tests++;
        if (wrap_up !== 1'b1 || wrap_cnt !== 8'd1) begin
            fails++;
            $display("FAIL post_reset_track: got wu=%b wc=%0d required wu=1 wc=1", wrap_up, wrap_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_wrap_up();
        test_load_clr();
        test_wrap_dn_clr();
        test_saturation();
        test_stall();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
